// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam int PC_INC  = 4;
  localparam int Q_DEPTH = 2;

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry FIFO of {pc, instr} toward decode; entry 0 is the registered head.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [Q_DEPTH-1:0][PC_W-1:0]    pc_q;
  logic [Q_DEPTH-1:0][INSTR_W-1:0] instr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      count   <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          pc_q[count[0]]    <= push_pc;
          instr_q[count[0]] <= push_instr;
          count             <= count + 2'd1;
        end
        2'b01: begin
          pc_q[0]    <= pc_q[1];
          instr_q[0] <= instr_q[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          // count stays; with one entry the new one becomes head directly
          if (count == 2'd1) begin
            pc_q[0]    <= push_pc;
            instr_q[0] <= push_instr;
          end else begin
            pc_q[0]    <= pc_q[1];
            instr_q[0] <= instr_q[1];
            pc_q[1]    <= push_pc;
            instr_q[1] <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_pc    = pc_q[0];
  assign head_instr = instr_q[0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: drives the PC register, requests imem, queues fetched words.
// Optional IFETCH_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_next,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  state_t          state, nxt;
  logic [PC_W-1:0] drop_addr;
  logic [1:0]      cnt;
  logic            deq, push, latch_drop;

  assign deq = if_valid && if_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drop_addr <= '0;
    end else begin
      state <= nxt;
      if (latch_drop) drop_addr <= pc;
    end
  end

  always_comb begin
    nxt        = state;
    imem_req   = 1'b0;
    imem_addr  = pc;
    pc_load    = 1'b0;
    pc_next    = pc + PC_W'(PC_INC);
    push       = 1'b0;
    latch_drop = 1'b0;
    case (state)
      S_IDLE: nxt = S_REQ;
      S_REQ: begin
        imem_req = (cnt < 2'(Q_DEPTH)) || deq;
        if (imem_req && imem_ack && !redirect_valid) begin
          push    = 1'b1;
          pc_load = 1'b1;
        end
        // orphaned request: remember its address and wait for its ack
        if (redirect_valid && imem_req && !imem_ack) begin
          nxt        = S_DROP;
          latch_drop = 1'b1;
        end
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (imem_ack) nxt = S_REQ;
      end
      default: nxt = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_load = 1'b1;
      pc_next = redirect_pc;
    end
  end

  ifetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (pc),
    .push_instr (imem_rdata),
    .pop        (deq),
    .flush      (redirect_valid),
    .count      (cnt),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (imem_req && !imem_ack && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a PC register and a variable-latency memory model.
module tb_ifetch_unit;
  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [PC_W-1:0]    pc, pc_next, redirect_pc, imem_addr, if_pc, pc_init;
  logic               pc_load, redirect_valid, imem_req, imem_ack, if_valid, if_ready;
  logic [INSTR_W-1:0] imem_rdata, if_instr;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif
  logic [7:0]         wcnt, lat;
  logic               man_ack;
  int                 checks = 0;
  int                 errors = 0;

  ifetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
`ifdef IFETCH_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_load        (pc_load),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [PC_W-1:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // PC register and memory: ack after `lat` wait cycles, or forced by man_ack
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= pc_init;
    else if (pc_load) pc <= pc_next;

  always_ff @(posedge clk or negedge reset)
    if (!reset) wcnt <= '0;
    else if (imem_ack) wcnt <= '0;
    else if (imem_req) wcnt <= wcnt + 8'd1;

  assign imem_ack   = imem_req && (man_ack || wcnt >= lat);
  assign imem_rdata = rd(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_load", 32'(pc_load), 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_ifpc", 32'(if_pc), 0);
`ifdef IFETCH_STALL_CNT_EN
    chk("rst_stall", 32'(stall_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic            rst;
    logic            rdy;
    logic            vld;
    logic [PC_W-1:0] ipc;
    logic            req;
    logic            ld;
    logic [PC_W-1:0] addr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // zero-wait, decode always ready
    tbl[0]  = '{1, 1, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0,  1, 1, 0};
    tbl[2]  = '{0, 1, 1, 0,  1, 1, 4};
    tbl[3]  = '{0, 1, 1, 4,  1, 1, 8};
    tbl[4]  = '{0, 1, 1, 8,  1, 1, 12};
    tbl[5]  = '{0, 1, 1, 12, 1, 1, 16};
    // decode stalled: queue fills with 0,4 and pc holds at 8, then drains
    tbl[6]  = '{1, 0, 0, 0,  0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,  1, 1, 0};
    tbl[8]  = '{0, 0, 1, 0,  1, 1, 4};
    tbl[9]  = '{0, 0, 1, 0,  0, 0, 8};
    tbl[10] = '{0, 0, 1, 0,  0, 0, 8};
    tbl[11] = '{0, 1, 1, 0,  1, 1, 8};
    tbl[12] = '{0, 1, 1, 4,  1, 1, 12};
    tbl[13] = '{0, 1, 1, 8,  1, 1, 16};
    tbl[14] = '{0, 1, 1, 12, 1, 1, 20};

    pc_init = '0; lat = '0; man_ack = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      else @(negedge clk);
      if_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("row%0d_load", i), 32'(pc_load), 32'(tbl[i].ld));
      chk($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      if (tbl[i].vld) begin
        chk($sformatf("row%0d_ifpc", i), 32'(if_pc), 32'(tbl[i].ipc));
        chk($sformatf("row%0d_instr", i), if_instr, rd(tbl[i].ipc));
      end
    end

    // 3-cycle ack: address held stable until ack
    lat = 8'd2; if_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("slow%0d_req", k), 32'(imem_req), 1);
      chk($sformatf("slow%0d_addr", k), 32'(imem_addr), 0);
      chk($sformatf("slow%0d_load", k), 32'(pc_load), (k == 3) ? 1 : 0);
    end
    @(negedge clk); #1;
    chk("slow_valid", 32'(if_valid), 1);
    chk("slow_ifpc", 32'(if_pc), 0);
    chk("slow_nextaddr", 32'(imem_addr), 4);
`ifdef IFETCH_STALL_CNT_EN
    chk("slow_stall", 32'(stall_cnt), 2);
`endif

    // redirect with request outstanding, then redirect coinciding with ack
    lat = 8'd255;
    do_reset();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 6'h20; #1;
    chk("rd1_req", 32'(imem_req), 1);
    chk("rd1_load", 32'(pc_load), 1);
    chk("rd1_next", 32'(pc_next), 32'h20);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("drop_req", 32'(imem_req), 1);
    chk("drop_addr", 32'(imem_addr), 0);
    chk("drop_load", 32'(pc_load), 0);
    chk("drop_valid", 32'(if_valid), 0);
    @(negedge clk); man_ack = 1'b1; #1;
    chk("drop_ack_load", 32'(pc_load), 0);
    chk("drop_ack_addr", 32'(imem_addr), 0);
    @(negedge clk); man_ack = 1'b0; lat = 8'd0; #1;
    chk("post_drop_valid", 32'(if_valid), 0);
    chk("post_drop_req", 32'(imem_req), 1);
    chk("post_drop_addr", 32'(imem_addr), 32'h20);
    chk("post_drop_next", 32'(pc_next), 32'h24);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 6'h10; #1;
    chk("tgt_valid", 32'(if_valid), 1);
    chk("tgt_ifpc", 32'(if_pc), 32'h20);
    chk("tgt_instr", if_instr, rd(6'h20));
    chk("rdack_load", 32'(pc_load), 1);
    chk("rdack_next", 32'(pc_next), 32'h10);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("rdack_flush", 32'(if_valid), 0);
    chk("rdack_req", 32'(imem_req), 1);
    chk("rdack_addr", 32'(imem_addr), 32'h10);
    @(negedge clk); #1;
    chk("rdack_deliver", 32'(if_valid), 1);
    chk("rdack_ifpc", 32'(if_pc), 32'h10);

    // PC wrap at 60, then asynchronous reset mid-request
    pc_init = 6'd60; lat = 8'd1;
    do_reset();
    @(negedge clk); #1;
    chk("wrap_addr", 32'(imem_addr), 60);
    chk("wrap_wait_load", 32'(pc_load), 0);
    @(negedge clk); #1;
    chk("wrap_load", 32'(pc_load), 1);
    chk("wrap_next", 32'(pc_next), 0);
    @(negedge clk); #1;
    chk("wrap_ifpc", 32'(if_pc), 60);
    chk("wrap_pc", 32'(imem_addr), 0);
    chk("wrap_req", 32'(imem_req), 1);
    reset = 1'b0; #1;
    chk("async_valid", 32'(if_valid), 0);
    chk("async_req", 32'(imem_req), 0);
    chk("async_load", 32'(pc_load), 0);
    @(negedge clk); reset = 1'b1; pc_init = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
